uart_tx_framer: RTL and testbench

UART_TX_FRAMER -- requirements
Module: uart_tx_framer

---
 rtl/uart_tx_pkg.sv | 31 +++
 rtl/uart_tx_framer_if.sv | 14 +
 rtl/uart_tx_bit_timer.sv | 32 +++
 rtl/uart_tx_framer.sv | 219 +++++++++++++++++++++
 tb/tb_uart_tx_framer.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit framer.
//   tx_state_e          : framer FSM states
//   DATA_BITS           : payload bits per frame
//   BREAK_BITS_DEFAULT  : default minimum break length in bit periods
//   calc_cycles_per_bit : clk_hz / baud, clamped to >= 1 (baud 0 also yields 1)
package uart_tx_pkg;

    localparam int unsigned DATA_BITS          = 8;
    localparam int unsigned BREAK_BITS_DEFAULT = 11;
    localparam int unsigned BIT_CNT_W          = 16;
    localparam int unsigned CPB_W              = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } tx_state_e;

    function automatic logic [CPB_W-1:0] calc_cycles_per_bit(
        input logic [CPB_W-1:0] clk_hz,
        input logic [CPB_W-1:0] baud
    );
        logic [CPB_W-1:0] q;
        q = (baud == '0) ? CPB_W'(1) : clk_hz / baud;
        return (q == '0) ? CPB_W'(1) : q;
    endfunction

endpackage

// File: rtl/uart_tx_framer_if.sv
// Byte handshake between a producer and the UART framer.
//   tx_data  : byte to send
//   tx_valid : producer has a byte
//   tx_ready : framer can take a byte this cycle
interface uart_tx_framer_if;
    import uart_tx_pkg::*;

    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_bit_timer.sv
// Bit-period timer: counts cycles_per_bit clocks while enabled and flags the
// last clock of every bit period.
//   clk, rst       : clock, async active-high reset
//   en             : count while high, held at zero otherwise
//   cycles_per_bit : bit period length in clocks (>= 1)
//   bit_end        : high on the last cycle of each bit period
module uart_tx_bit_timer
    import uart_tx_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CPB_W-1:0] cycles_per_bit,
    output logic             bit_end
);

    logic [CPB_W-1:0] cnt_q;

    assign bit_end = en && (cnt_q == cycles_per_bit - CPB_W'(1));

    // Free-running within a frame; wraps at each bit boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (!en || bit_end) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CPB_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, 8 data bits LSB first, optional parity,
// 1 or 2 stop bits, plus line-break generation.
//   clk, rst            : clock, async active-high reset
//   bus (slave)         : tx_data / tx_valid / tx_ready byte handshake
//   baud_rate           : bits/s; 0 disables transmission
//   parity_en/odd       : parity enable, 1 = odd parity
//   stop_bits2          : 1 = two stop bits
//   break_req           : request a break (sampled in idle only)
//   inject_parity_err   : invert parity bit   (UART_TX_ERR_INJECT_EN builds)
//   inject_frame_err    : low first stop bit  (UART_TX_ERR_INJECT_EN builds)
//   tx                  : serial line, idle high
//   tx_busy             : not idle
//   frame_done          : one-cycle pulse on return to idle
//   break_active        : line held low by a break
// Define UART_TX_ERR_INJECT_EN to build the error-injection logic.
module uart_tx_framer #(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned BREAK_BITS  = uart_tx_pkg::BREAK_BITS_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    uart_tx_framer_if.slave         bus,
    input  logic [31:0]             baud_rate,
    input  logic                    parity_en,
    input  logic                    parity_odd,
    input  logic                    stop_bits2,
    input  logic                    break_req,
    input  logic                    inject_parity_err,
    input  logic                    inject_frame_err,
    output logic                    tx,
    output logic                    tx_busy,
    output logic                    frame_done,
    output logic                    break_active
);
    import uart_tx_pkg::*;

    tx_state_e              state_q, state_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic                   brk_hi_q, brk_hi_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_bit_q, par_bit_d;
    logic                   par_en_q, par_en_d;
    logic                   stop2_q, stop2_d;
    logic [CPB_W-1:0]       cpb_q, cpb_d;
    logic                   tx_d, busy_d, done_d, brk_act_d;
    logic                   bit_end;

`ifdef UART_TX_ERR_INJECT_EN
    logic                   inj_frm_q, inj_frm_d;
`else
    logic                   unused_inj;
    assign unused_inj = inject_parity_err ^ inject_frame_err;
`endif

    assign bus.tx_ready = (state_q == ST_IDLE) && (baud_rate != '0) && !break_req;

    uart_tx_bit_timer u_bit_timer (
        .clk            (clk),
        .rst            (rst),
        .en             (state_q != ST_IDLE),
        .cycles_per_bit (cpb_q),
        .bit_end        (bit_end)
    );

    // Next state, latched frame parameters and next registered outputs.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        brk_hi_d  = brk_hi_q;
        shift_d   = shift_q;
        par_bit_d = par_bit_q;
        par_en_d  = par_en_q;
        stop2_d   = stop2_q;
        cpb_d     = cpb_q;
`ifdef UART_TX_ERR_INJECT_EN
        inj_frm_d = inj_frm_q;
`endif
        done_d    = 1'b0;
        tx_d      = 1'b1;
        busy_d    = 1'b0;
        brk_act_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                bit_cnt_d = '0;
                brk_hi_d  = 1'b0;
                if (break_req) begin
                    state_d = ST_BREAK;
                    cpb_d   = calc_cycles_per_bit(CPB_W'(CLK_FREQ_HZ), baud_rate);
                end else if (bus.tx_valid && bus.tx_ready) begin
                    state_d   = ST_START;
                    cpb_d     = calc_cycles_per_bit(CPB_W'(CLK_FREQ_HZ), baud_rate);
                    shift_d   = bus.tx_data;
                    par_en_d  = parity_en;
                    stop2_d   = stop_bits2;
                    par_bit_d = (^bus.tx_data) ^ parity_odd;
`ifdef UART_TX_ERR_INJECT_EN
                    par_bit_d = par_bit_d ^ inject_parity_err;
                    inj_frm_d = inject_frame_err;
`endif
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == BIT_CNT_W'(DATA_BITS - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (stop2_q && (bit_cnt_q == '0)) begin
                        bit_cnt_d = BIT_CNT_W'(1);
                    end else begin
                        state_d   = ST_IDLE;
                        bit_cnt_d = '0;
                        done_d    = 1'b1;
                    end
                end
            end
            ST_BREAK: begin
                // Low phase counts bit periods (saturating) and ends on the first
                // boundary at or past BREAK_BITS where break_req has dropped;
                // then one high recovery bit.
                if (bit_end) begin
                    if (brk_hi_q) begin
                        state_d   = ST_IDLE;
                        brk_hi_d  = 1'b0;
                        bit_cnt_d = '0;
                        done_d    = 1'b1;
                    end else if (bit_cnt_q >= BIT_CNT_W'(BREAK_BITS - 1)) begin
                        if (!break_req) begin
                            brk_hi_d  = 1'b1;
                            bit_cnt_d = '0;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered with the state, so they are derived from state_d.
        busy_d = (state_d != ST_IDLE);
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = par_bit_d;
            ST_STOP: begin
`ifdef UART_TX_ERR_INJECT_EN
                tx_d = !(inj_frm_d && (bit_cnt_d == '0));
`else
                tx_d = 1'b1;
`endif
            end
            ST_BREAK: begin
                tx_d      = brk_hi_d;
                brk_act_d = !brk_hi_d;
            end
            default:   tx_d = 1'b1;
        endcase
    end

    // State, frame context and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            brk_hi_q     <= 1'b0;
            shift_q      <= '0;
            par_bit_q    <= 1'b0;
            par_en_q     <= 1'b0;
            stop2_q      <= 1'b0;
            cpb_q        <= '0;
`ifdef UART_TX_ERR_INJECT_EN
            inj_frm_q    <= 1'b0;
`endif
            tx           <= 1'b1;
            tx_busy      <= 1'b0;
            frame_done   <= 1'b0;
            break_active <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            brk_hi_q     <= brk_hi_d;
            shift_q      <= shift_d;
            par_bit_q    <= par_bit_d;
            par_en_q     <= par_en_d;
            stop2_q      <= stop2_d;
            cpb_q        <= cpb_d;
`ifdef UART_TX_ERR_INJECT_EN
            inj_frm_q    <= inj_frm_d;
`endif
            tx           <= tx_d;
            tx_busy      <= busy_d;
            frame_done   <= done_d;
            break_active <= brk_act_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Randomized self-checking bench for uart_tx_framer against a bit-list
// reference model of the UART frame and break timing.
module tb_uart_tx_framer;
    import uart_tx_pkg::*;

    localparam int unsigned CLK_HZ = 100_000_000;
    localparam int unsigned BRK    = 11;
`ifdef UART_TX_ERR_INJECT_EN
    localparam bit INJ = 1'b1;
`else
    localparam bit INJ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] baud_rate;
    logic        parity_en, parity_odd, stop_bits2;
    logic        break_req, inject_parity_err, inject_frame_err;
    logic        tx, tx_busy, frame_done, break_active;

    int n_checks = 0;
    int n_errors = 0;

    uart_tx_framer_if bus_if ();

    uart_tx_framer #(.CLK_FREQ_HZ(CLK_HZ), .BREAK_BITS(BRK)) dut (
        .clk               (clk),
        .rst               (rst),
        .bus               (bus_if),
        .baud_rate         (baud_rate),
        .parity_en         (parity_en),
        .parity_odd        (parity_odd),
        .stop_bits2        (stop_bits2),
        .break_req         (break_req),
        .inject_parity_err (inject_parity_err),
        .inject_frame_err  (inject_frame_err),
        .tx                (tx),
        .tx_busy           (tx_busy),
        .frame_done        (frame_done),
        .break_active      (break_active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned ref_cpb(input logic [31:0] baud);
        int unsigned q;
        if (baud == 32'd0) return 1;
        q = CLK_HZ / baud;
        return (q == 0) ? 1 : q;
    endfunction

    task automatic scramble();
        bus_if.tx_data    = 8'($urandom);
        parity_en         = 1'($urandom);
        parity_odd        = 1'($urandom);
        stop_bits2        = 1'($urandom);
        inject_parity_err = 1'($urandom);
        inject_frame_err  = 1'($urandom);
        baud_rate         = $urandom_range(5_000_000, 60_000_000);
    endtask

    // Called between the acceptance-cycle negedge and the acceptance edge.
    task automatic expect_frame(input logic [7:0] d, input bit pe, input bit po, input bit s2,
                                input bit ip, input bit ifr, input logic [31:0] baud,
                                input bit brk_mid);
        bit          bits[$];
        int unsigned cpb, len;
        cpb = ref_cpb(baud);
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (pe) bits.push_back((^d) ^ po ^ (INJ & ip));
        bits.push_back(!(INJ & ifr));
        if (s2) bits.push_back(1'b1);
        len = 32'(bits.size()) * cpb;
        for (int unsigned k = 1; k <= len; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                bus_if.tx_valid = 1'b0;
                scramble();
            end
            break_req = brk_mid && (k >= len / 2);
            @(negedge clk);
            chk("frame_tx", 32'(tx), 32'(bits[(k - 1) / cpb]));
            chk("frame_busy", 32'(tx_busy), 32'd1);
            chk("frame_done_early", 32'(frame_done), 32'd0);
            chk("frame_brk_active", 32'(break_active), 32'd0);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("frame_done", 32'(frame_done), 32'd1);
        chk("idle_tx", 32'(tx), 32'd1);
        chk("idle_busy", 32'(tx_busy), 32'd0);
        chk("ready_after_done", 32'(bus_if.tx_ready), brk_mid ? 32'd0 : 32'd1);
    endtask

    // Called before the break-entry edge; break_req stays high for 'hold'
    // cycles after entry.
    task automatic expect_break(input int unsigned hold);
        int unsigned cpb, m, low_len;
        cpb = ref_cpb(baud_rate);
        m = hold / cpb + 1;
        if (m < BRK) m = BRK;
        low_len = m * cpb;
        for (int unsigned k = 1; k <= low_len + cpb; k++) begin
            @(posedge clk);
            #1;
            break_req = (k <= hold);
            @(negedge clk);
            chk("brk_tx", 32'(tx), (k <= low_len) ? 32'd0 : 32'd1);
            chk("brk_active", 32'(break_active), (k <= low_len) ? 32'd1 : 32'd0);
            chk("brk_busy", 32'(tx_busy), 32'd1);
            chk("brk_done_early", 32'(frame_done), 32'd0);
        end
        @(posedge clk);
        #1;
        break_req = 1'b0;
        @(negedge clk);
        chk("brk_done", 32'(frame_done), 32'd1);
        chk("brk_idle_tx", 32'(tx), 32'd1);
        chk("brk_idle_busy", 32'(tx_busy), 32'd0);
        chk("brk_idle_active", 32'(break_active), 32'd0);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit pe, input bit po, input bit s2,
                              input bit ip, input bit ifr, input logic [31:0] baud,
                              input bit brk_mid);
        @(posedge clk);
        #1;
        bus_if.tx_data    = d;
        parity_en         = pe;
        parity_odd        = po;
        stop_bits2        = s2;
        inject_parity_err = ip;
        inject_frame_err  = ifr;
        baud_rate         = baud;
        break_req         = 1'b0;
        bus_if.tx_valid   = 1'b1;
        @(negedge clk);
        chk("tx_ready", 32'(bus_if.tx_ready), 32'd1);
        expect_frame(d, pe, po, s2, ip, ifr, baud, brk_mid);
    endtask

    initial begin
        bit seen_done;
        rst               = 1'b1;
        baud_rate         = 32'd10_000_000;
        bus_if.tx_data    = 8'h00;
        bus_if.tx_valid   = 1'b0;
        parity_en         = 1'b0;
        parity_odd        = 1'b0;
        stop_bits2        = 1'b0;
        break_req         = 1'b0;
        inject_parity_err = 1'b0;
        inject_frame_err  = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(tx_busy), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_brk_active", 32'(break_active), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", 32'(bus_if.tx_ready), 32'd1);

        // 0xA5 plain, even parity, odd parity, two stop bits
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd10_000_000, 1'b0);
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd10_000_000, 1'b0);
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd10_000_000, 1'b0);
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd10_000_000, 1'b0);
        // Injection inputs (effective only in injection builds)
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'd10_000_000, 1'b0);

        // Break pulse with a byte offered in the same cycle
        @(posedge clk);
        #1;
        bus_if.tx_data    = 8'h3C;
        parity_en         = 1'b1;
        parity_odd        = 1'b1;
        stop_bits2        = 1'b0;
        inject_parity_err = 1'b0;
        inject_frame_err  = 1'b0;
        baud_rate         = 32'd10_000_000;
        bus_if.tx_valid   = 1'b1;
        break_req         = 1'b1;
        @(negedge clk);
        chk("ready_vs_break", 32'(bus_if.tx_ready), 32'd0);
        expect_break(0);
        chk("ready_after_break", 32'(bus_if.tx_ready), 32'd1);
        expect_frame(8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd10_000_000, 1'b0);

        // Zero baud rate blocks transfers
        @(posedge clk);
        #1;
        baud_rate       = 32'd0;
        bus_if.tx_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("baud0_ready", 32'(bus_if.tx_ready), 32'd0);
            chk("baud0_tx", 32'(tx), 32'd1);
            chk("baud0_busy", 32'(tx_busy), 32'd0);
        end
        @(posedge clk);
        #1;
        bus_if.tx_valid = 1'b0;
        baud_rate       = 32'd10_000_000;

        // Randomized frames, some with a break requested mid-frame
        for (int i = 0; i < 16; i++) begin
            logic [31:0] b;
            bit          mid;
            b   = $urandom_range(5_000_000, 120_000_000);
            mid = (i % 4 == 3);
            send_frame(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                       1'($urandom), 1'($urandom), b, mid);
            if (mid) expect_break($urandom_range(0, 40));
        end

        // Reset during data bit 3 of 0xA5 (bit value 0)
        @(posedge clk);
        #1;
        bus_if.tx_data  = 8'hA5;
        parity_en       = 1'b0;
        stop_bits2      = 1'b0;
        baud_rate       = 32'd10_000_000;
        bus_if.tx_valid = 1'b1;
        @(negedge clk);
        chk("rst_mid_ready", 32'(bus_if.tx_ready), 32'd1);
        @(posedge clk);
        #1;
        bus_if.tx_valid = 1'b0;
        repeat (44) @(posedge clk);
        @(negedge clk);
        chk("rst_mid_pre_tx", 32'(tx), 32'd0);
        chk("rst_mid_pre_busy", 32'(tx_busy), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_tx", 32'(tx), 32'd1);
        chk("rst_mid_busy", 32'(tx_busy), 32'd0);
        chk("rst_mid_done", 32'(frame_done), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            seen_done = seen_done | frame_done | !tx;
        end
        chk("rst_mid_no_done", 32'(seen_done), 32'd0);

        // Recovery after reset
        send_frame(8'h5A, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd10_000_000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
